// File: rtl/div_unit.sv
// Multi-cycle restoring divider for div.w/mod.w/div.wu/mod.wu.
// One quotient bit per cycle; flush or reset cancels the operation.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quot,
  output logic [WIDTH-1:0] res_rem,
  output logic             res_dbz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] src1_q;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   sh;
  logic             ge;

  assign accept = div_valid & div_ready;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign a_abs = (div_signed && div_src1[WIDTH-1])
               ? -div_src1 : div_src1;
  assign b_abs = (div_signed && div_src2[WIDTH-1])
               ? -div_src2 : div_src2;

  // Partial remainder with the next dividend bit shifted in.
  assign sh = {rem, quot[WIDTH-1]};
  assign ge = (sh >= {1'b0, dvs});

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; flush wins from any state.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nx = CALC;
        CALC:    if (last) state_nx = DONE;
        DONE:    if (res_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Handshake and result outputs; zero unless presenting a result.
  always_comb begin
    div_ready = (state == IDLE) && !flush;
    res_valid = (state == DONE);
    res_quot  = '0;
    res_rem   = '0;
    res_dbz   = 1'b0;
    if (res_valid) begin
      if (dbz) begin
        res_quot = '1;
        res_rem  = src1_q;
        res_dbz  = 1'b1;
      end else begin
        res_quot = q_neg ? -quot : quot;
        res_rem  = r_neg ? -rem : rem;
      end
    end
  end

  // Operand capture at accept, then one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      quot   <= '0;
      rem    <= '0;
      dvs    <= '0;
      src1_q <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dbz    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      quot   <= a_abs;
      rem    <= '0;
      dvs    <= b_abs;
      src1_q <= div_src1;
      q_neg  <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
      r_neg  <= div_signed & div_src1[WIDTH-1];
      dbz    <= (div_src2 == '0);
    end else if (state == CALC) begin
      cnt  <= cnt + 1'b1;
      rem  <= ge ? WIDTH'(sh - {1'b0, dvs}) : WIDTH'(sh);
      quot <= {quot[WIDTH-2:0], ge};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results,
// divide by zero, backpressure, flush and mid-operation reset.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_quot;
  logic [31:0] res_rem;
  logic        res_dbz;

  int n_cmp;
  int n_bad;

  div_unit #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_signed(div_signed),
    .div_src1  (div_src1),
    .div_src2  (div_src2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_quot  (res_quot),
    .res_rem   (res_rem),
    .res_dbz   (res_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation and return #1 after the accept edge.
  task automatic issue(input logic sg,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    div_valid  = 1'b1;
    div_signed = sg;
    div_src1   = a;
    div_src2   = b;
    chk("accept_ready", 32'(div_ready), 32'd1);
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    div_signed = ~sg;
    div_src1   = $urandom;
    div_src2   = $urandom;
  endtask

  // Wait the fixed latency; result must not show early.
  task automatic wait_lat(input string tag);
    logic early;
    early = 1'b0;
    repeat (31) begin
      @(posedge clk);
      #1;
      if (res_valid) early = 1'b1;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic chk_res(input string tag,
                         input logic [31:0] q,
                         input logic [31:0] r,
                         input logic z);
    chk({tag, "_quot"}, res_quot, q);
    chk({tag, "_rem"}, res_rem, r);
    chk({tag, "_dbz"}, 32'(res_dbz), 32'(z));
  endtask

  task automatic full(input string tag,
                      input logic sg,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] q,
                      input logic [31:0] r,
                      input logic z);
    res_ready = 1'b1;
    issue(sg, a, b);
    wait_lat(tag);
    chk_res(tag, q, r, z);
    chk({tag, "_busy"}, 32'(div_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(div_ready), 32'd1);
    chk({tag, "_q0"}, res_quot, 32'd0);
  endtask

  // Watch for a result that must never appear.
  task automatic no_result(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    resetn     = 1'b0;
    flush      = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_src1   = '0;
    div_src2   = '0;
    res_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk_res("rst", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_ready", 32'(div_ready), 32'd1);

    full("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    full("s-7_2", 1'b1, 32'hFFFFFFF9, 32'h2,
         32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    full("s7_-2", 1'b1, 32'h7, 32'hFFFFFFFE,
         32'hFFFFFFFD, 32'h1, 1'b0);
    full("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
         32'h80000000, 32'h0, 1'b0);
    full("u_big", 1'b0, 32'hFFFFFFFF, 32'h10,
         32'h0FFFFFFF, 32'hF, 1'b0);
    full("s_dbz", 1'b1, 32'h1234, 32'h0,
         32'hFFFFFFFF, 32'h1234, 1'b1);
    full("u_dbz", 1'b0, 32'h1234, 32'h0,
         32'hFFFFFFFF, 32'h1234, 1'b1);
    full("u_sgn_in", 1'b0, 32'hFFFFFFF9, 32'h2,
         32'h7FFFFFFC, 32'h1, 1'b0);

    // Backpressure: hold res_ready low for 5 cycles in DONE.
    res_ready = 1'b0;
    issue(1'b0, 32'd20, 32'd6);
    wait_lat("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk_res("bp_hold", 32'd3, 32'd2, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("bp_still", 32'(res_valid), 32'd1);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done", 32'(res_valid), 32'd0);
    chk("bp_idle", 32'(div_ready), 32'd1);

    // Flush during CALC.
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_ready_lo", 32'(div_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    chk("fl_ready", 32'(div_ready), 32'd1);
    no_result("fl_noresult");
    full("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Flush together with div_valid in IDLE.
    @(negedge clk);
    flush      = 1'b1;
    div_valid  = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd40;
    div_src2   = 32'd4;
    #1;
    chk("fi_ready", 32'(div_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    div_valid = 1'b0;
    no_result("fi_noresult");
    chk("fi_idle", 32'(div_ready), 32'd1);

    // Reset at cycle 15 of CALC.
    issue(1'b0, 32'd77, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mr_valid", 32'(res_valid), 32'd0);
    chk_res("mr", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("mr_ready", 32'(div_ready), 32'd1);
    no_result("mr_noresult");
    full("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
